// File: rtl/vga_sync_if.sv
// vga_sync_if: pixel-clock input and raster timing outputs of vga_sync.
// frame_cnt exists only when VGA_SYNC_FRAME_CNT_EN is defined.
interface vga_sync_if #(parameter int CNT_W = 10);
   logic             dclk;
   logic             pix_tick;
   logic [CNT_W-1:0] hcount;
   logic [CNT_W-1:0] vcount;
   logic             hsync;
   logic             vsync;
   logic             video_on;
   logic             line_start;
   logic             frame_start;
`ifdef VGA_SYNC_FRAME_CNT_EN
   logic [7:0]       frame_cnt;
   modport master (input dclk, output pix_tick, hcount, vcount, hsync, vsync, video_on,
                   line_start, frame_start, frame_cnt);
   modport slave (output dclk, input pix_tick, hcount, vcount, hsync, vsync, video_on,
                  line_start, frame_start, frame_cnt);
`else
   modport master (input dclk, output pix_tick, hcount, vcount, hsync, vsync, video_on,
                   line_start, frame_start);
   modport slave (output dclk, input pix_tick, hcount, vcount, hsync, vsync, video_on,
                  line_start, frame_start);
`endif
endinterface

// File: rtl/vga_sync.sv
// vga_sync: VGA raster timing generator ticking on rising edges of dclk sampled on clk.
// Optional VGA_SYNC_FRAME_CNT_EN adds an 8-bit frame counter output.
module vga_sync #(
   parameter int H_VISIBLE = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter int SYNC_POL  = 0,
   parameter int CNT_W     = 10
) (
   input logic          clk,
   input logic          reset,
   vga_sync_if.master   bus
);
   localparam logic [CNT_W-1:0] H_MAX = CNT_W'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [CNT_W-1:0] V_MAX = CNT_W'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [CNT_W-1:0] H_VIS = CNT_W'(H_VISIBLE);
   localparam logic [CNT_W-1:0] V_VIS = CNT_W'(V_VISIBLE);
   localparam logic [CNT_W-1:0] H_SS  = CNT_W'(H_VISIBLE + H_FP);
   localparam logic [CNT_W-1:0] H_SE  = CNT_W'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] V_SS  = CNT_W'(V_VISIBLE + V_FP);
   localparam logic [CNT_W-1:0] V_SE  = CNT_W'(V_VISIBLE + V_FP + V_SYNC);
   localparam logic             POL   = (SYNC_POL != 0);
   logic             dclk_d, dclk_q, tick, h_wrap;
   logic [CNT_W-1:0] hcount_d, hcount_q, vcount_d, vcount_q;
   logic             hsync_d, hsync_q, vsync_d, vsync_q, video_on_d, video_on_q;
   logic             pix_tick_d, pix_tick_q, line_start_d, line_start_q;
   logic             frame_start_d, frame_start_q;
   always_comb begin
      dclk_d        = bus.dclk;
      tick          = bus.dclk & ~dclk_q;
      h_wrap        = hcount_q == H_MAX;
      hcount_d      = tick ? (h_wrap ? '0 : hcount_q + 1'b1) : hcount_q;
      vcount_d      = (tick && h_wrap) ? ((vcount_q == V_MAX) ? '0 : vcount_q + 1'b1) : vcount_q;
      // levels follow the next counters so they line up with hcount/vcount
      hsync_d       = (hcount_d >= H_SS && hcount_d < H_SE) ? POL : ~POL;
      vsync_d       = (vcount_d >= V_SS && vcount_d < V_SE) ? POL : ~POL;
      video_on_d    = (hcount_d < H_VIS) && (vcount_d < V_VIS);
      pix_tick_d    = tick;
      line_start_d  = tick && (hcount_d == '0);
      frame_start_d = line_start_d && (vcount_d == '0);
   end
   // dclk_q resets high so a dclk already high at release is not a tick
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dclk_q        <= 1'b1;
         hcount_q      <= H_MAX;
         vcount_q      <= V_MAX;
         hsync_q       <= ~POL;
         vsync_q       <= ~POL;
         video_on_q    <= 1'b0;
         pix_tick_q    <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         dclk_q        <= dclk_d;
         hcount_q      <= hcount_d;
         vcount_q      <= vcount_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         video_on_q    <= video_on_d;
         pix_tick_q    <= pix_tick_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end
   assign bus.pix_tick    = pix_tick_q;
   assign bus.hcount      = hcount_q;
   assign bus.vcount      = vcount_q;
   assign bus.hsync       = hsync_q;
   assign bus.vsync       = vsync_q;
   assign bus.video_on    = video_on_q;
   assign bus.line_start  = line_start_q;
   assign bus.frame_start = frame_start_q;
`ifdef VGA_SYNC_FRAME_CNT_EN
   logic [7:0] frame_cnt_d, frame_cnt_q;
   always_comb frame_cnt_d = frame_cnt_q + 8'(frame_start_d);
   always_ff @(posedge clk or posedge reset) begin
      if (reset) frame_cnt_q <= 8'd0;
      else frame_cnt_q <= frame_cnt_d;
   end
   assign bus.frame_cnt = frame_cnt_q;
`endif
endmodule

// File: tb/tb_vga_sync.sv
// tb_vga_sync: randomized dclk against a linear pixel-index reference model.
// Small raster parameters keep whole frames (and 257 frames with VGA_SYNC_FRAME_CNT_EN) short.
module tb_vga_sync;
   localparam int HV = 4, HFP = 1, HS = 2, HBP = 1;
   localparam int VV = 3, VFP = 1, VS = 1, VBP = 1;
   localparam int HT = HV + HFP + HS + HBP;
   localparam int VT = VV + VFP + VS + VBP;
   localparam int FRAME = HT * VT;
`ifdef VGA_SYNC_FRAME_CNT_EN
   localparam int N_FR = 257;
`else
   localparam int N_FR = 3;
`endif
   logic clk = 1'b0;
   logic reset = 1'b1;
   vga_sync_if #(.CNT_W(10)) bus();
   vga_sync #(.H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
              .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
              .SYNC_POL(0), .CNT_W(10)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   int n_chk = 0, n_fail = 0;
   int idx, frames;
   bit prev_d, tick_e;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d (idx %0d)", tag, obs, exp, idx);
      end
   endtask
   // Expected raster position is the pixel index within the frame.
   task automatic check_all();
      int h = idx % HT;
      int v = idx / HT;
      chk("hcount", 32'(bus.hcount), 32'(h));
      chk("vcount", 32'(bus.vcount), 32'(v));
      chk("hsync", 32'(bus.hsync), (h >= HV + HFP && h < HV + HFP + HS) ? 0 : 1);
      chk("vsync", 32'(bus.vsync), (v >= VV + VFP && v < VV + VFP + VS) ? 0 : 1);
      chk("video_on", 32'(bus.video_on), (h < HV && v < VV) ? 1 : 0);
      chk("pix_tick", 32'(bus.pix_tick), 32'(tick_e));
      chk("line_start", 32'(bus.line_start), (tick_e && h == 0) ? 1 : 0);
      chk("frame_start", 32'(bus.frame_start), (tick_e && idx == 0) ? 1 : 0);
`ifdef VGA_SYNC_FRAME_CNT_EN
      chk("frame_cnt", 32'(bus.frame_cnt), 32'(frames % 256));
`endif
   endtask
   task automatic cycle(input bit d);
      bus.dclk = d;
      tick_e = d & ~prev_d;
      prev_d = d;
      if (tick_e) begin
         idx = (idx + 1) % FRAME;
         if (idx == 0) frames++;
      end
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask
   task automatic rand_tick();
      repeat ($urandom_range(1, 3)) cycle(1'b0);
      repeat ($urandom_range(1, 3)) cycle(1'b1);
   endtask
   task automatic model_reset();
      idx = FRAME - 1;
      prev_d = 1'b1;
      tick_e = 1'b0;
      frames = 0;
   endtask
   initial begin
      bus.dclk = 1'b1;
      model_reset();
      repeat (3) @(negedge clk);
      check_all();
      reset = 1'b0;
      repeat (10) cycle(1'b1);
      chk("rst_hcount_last", 32'(bus.hcount), 32'(HT - 1));
      chk("rst_vcount_last", 32'(bus.vcount), 32'(VT - 1));
      cycle(1'b0);
      cycle(1'b1);
      chk("first_frame_start", 32'(bus.frame_start), 1);
      cycle(1'b1);
      chk("strobe_drop", 32'(bus.pix_tick), 0);
      repeat (2 * HT) begin
         cycle(1'b0); cycle(1'b0); cycle(1'b1); cycle(1'b1);
      end
      while (frames < 3) rand_tick();
      while (idx != FRAME / 2 + 3) rand_tick();
      cycle(1'b0);
      reset = 1'b1;
      #1;
      model_reset();
      check_all();
      @(negedge clk);
      check_all();
      reset = 1'b0;
      cycle(1'b1);
      cycle(1'b0);
      cycle(1'b1);
      chk("post_reset_frame_start", 32'(bus.frame_start), 1);
      while (frames < N_FR) rand_tick();
      repeat (4) rand_tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/vga_sync.md
Name: vga_sync

Overview:
- VGA raster timing generator; consumer of the divided pixel clock `dclk` produced by the clock divider.
- Samples `dclk` in the master `clk` domain and detects its rising edges; each edge is one pixel tick.
- On each tick: advances horizontal/vertical counters, produces hsync/vsync, video_on and line/frame strobes.
- Feeds the pixel/graphics logic and the VGA connector pins.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (ticks)
- H_SYNC, 96, horizontal sync width (ticks)
- H_BP, 48, horizontal back porch (ticks)
- V_VISIBLE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, sync active level (0 = active-low)
- CNT_W, 10, width of hcount/vcount

Ports:
- clk  in  1  master clock, 50 MHz
- reset  in  1  asynchronous reset, active-high
- dclk  in  1  divided pixel clock level from the divider, sampled on clk
- pix_tick  out  1  one-clk strobe, high in the cycle counters update
- hcount  out  CNT_W  current pixel column
- vcount  out  CNT_W  current line
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- video_on  out  1  high when hcount < H_VISIBLE and vcount < V_VISIBLE
- line_start  out  1  one-clk strobe when hcount becomes 0
- frame_start  out  1  one-clk strobe when (hcount, vcount) becomes (0,0)
- frame_cnt  out  8  frames since reset (only with FRAME_CNT_EN)

Behaviour:
- Timing constants: H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800); V_TOTAL = sum of V_* (525).
- Edge detect:
  - dclk_q <= dclk every clk.
  - tick = dclk & ~dclk_q.
  - dclk_q resets to 1, so a high dclk at reset release gives no spurious tick.
- On tick:
  - If hcount == H_TOTAL-1: hcount <= 0, and vcount <= (vcount == V_TOTAL-1) ? 0 : vcount+1.
  - Otherwise: hcount <= hcount+1, vcount holds.
- No tick: all counters and level outputs hold; strobes are 0.
- All outputs are registered and computed from the next counter values, so they align with hcount/vcount in the same cycle.
- hsync is active (== SYNC_POL) iff H_VISIBLE+H_FP <= hcount < H_VISIBLE+H_FP+H_SYNC (656..751).
- vsync is active iff V_VISIBLE+V_FP <= vcount < V_VISIBLE+V_FP+V_SYNC (490..491).
- pix_tick, line_start and frame_start are single-cycle pulses and never last longer than one clk.
- Reset values:
  - hcount = H_TOTAL-1, vcount = V_TOTAL-1.
  - hsync = vsync = ~SYNC_POL (inactive).
  - video_on = 0; pix_tick = line_start = frame_start = 0.
  - This makes the first tick after reset land on (0,0) with frame_start = 1, so pixel (0,0) of the first frame is not lost.
- Reset mid-frame: asynchronously returns every register to its reset value within the same clk; no partial-frame state survives.
- dclk held constant: no ticks, outputs frozen indefinitely.
- Tick rate: any dclk frequency below clk/2 is valid; tick spacing need not be uniform.

Optional Feature:
- Macro: VGA_SYNC_FRAME_CNT_EN.
- Defined:
  - Adds 8-bit output frame_cnt, reset 0.
  - Increments in the same cycle frame_start pulses; wraps 255 -> 0.
  - The first frame_start after reset sets it to 1.
- Undefined: frame_cnt port and its register are absent; all other behaviour is identical.

Test Plan:
- Reset release with dclk=1 held for 10 clk -> no pix_tick; hcount=799, vcount=524, hsync=vsync=1, video_on=0.
- First dclk rising edge after reset -> 1 clk later hcount=0, vcount=0, video_on=1, frame_start=1, line_start=1, pix_tick=1; the next cycle all strobes are 0.
- Drive dclk = clk/4 for one full line -> hsync low exactly for hcount 656..751 (96 ticks); video_on low from hcount 640; after hcount 799, wrap to 0 with vcount=1 and line_start=1.
- Run a full frame -> vsync low only for vcount 490..491; after tick at (799,524), frame_start pulses at (0,0); 800*525 = 420000 ticks per frame.
- Assert reset at (300,200) mid-frame -> same-cycle return to (799,524) with outputs inactive; the next tick gives frame_start.
- With VGA_SYNC_FRAME_CNT_EN: run 257 frames -> frame_cnt reads 1 after the first frame_start and 0 after the 256th; compile without the macro -> elaborates with no frame_cnt port.
